// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX fetch stage.
//   DLX_NOP       : all-zero word (opcode 0, func 0, Rd r0), used as the bubble
//   DLX_PC_INC    : byte increment between consecutive instruction words
//   fetch_state_t : fetch control state (RUN issues, FLUSH drains stale responses)
//   fetch_entry_t : prefetch buffer entry, instruction word plus its PC
package dlx_pkg;

    localparam logic [31:0] DLX_NOP    = 32'h0000_0000;
    localparam logic [31:0] DLX_PC_INC = 32'd4;

    typedef enum logic {
        RUN,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// Prefetch buffer for the DLX fetch stage: synchronous FIFO of fetch_entry_t.
//   clk, reset_n : clock, synchronous active-low reset
//   flush_i      : empty the buffer (wins over push/pop in the same cycle)
//   push_i       : write push_data_i
//   pop_i        : drop the head entry (ignored when empty)
//   pop_data_o   : head entry, valid while empty_o is low
//   empty_o      : no entries held
//   count_o      : number of entries held (0..DEPTH)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module dlx_fetch_fifo
    import dlx_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  pop_data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/dlx_fetch.sv
// DLX instruction-fetch stage. Owns the PC, issues in-order word requests over a
// req/gnt/rvalid memory port, buffers returned words and hands one instruction
// per cycle to the decoder, inserting NOP bubbles when nothing is available.
//   clk, reset_n          : clock, synchronous active-low reset
//   stall                 : hold the current decoder output
//   redirect_valid/_pc    : taken branch/jump, restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req/_addr/_gnt   : request channel, req & gnt issues one word fetch
//   imem_rvalid/_rdata    : in-order response channel
//   instr/_pc/_valid      : registered decoder-facing instruction, its PC, real-vs-bubble
// Optional: define DLX_FETCH_PERF_EN to add saturating counters perf_bubbles,
// perf_redirects and perf_dropped.
module dlx_fetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
`ifdef DLX_FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [15:0] perf_redirects,
    output logic [15:0] perf_dropped
`endif
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic          instr_valid_q, instr_valid_d;

    logic          issue;
    logic          resp;
    logic          drop_resp;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_in;
    logic [31:0]   redirect_aligned;
    logic          unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Words in flight plus words buffered never exceed the buffer depth, so a
    // returning response always has room.
    assign imem_req  = reset_n && (state_q == RUN) && !redirect_valid &&
                       (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W);
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. stale after reset) is ignored.
    assign resp      = imem_rvalid && (outstanding_q != '0);
    assign drop_resp = resp && ((drop_q != '0) || redirect_valid);
    assign push      = resp && !drop_resp;
    assign pop       = !redirect_valid && !stall && !fifo_empty;

    assign fifo_in.instr = imem_rdata;
    assign fifo_in.pc    = resp_pc_q;

    dlx_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (fifo_in),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign outstanding_d = outstanding_q + CW'(issue) - CW'(resp);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + DLX_PC_INC;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + DLX_PC_INC;
        end
        if (resp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if ((state_q == FLUSH) && (drop_d == '0)) begin
            state_d = RUN;
        end

        // Output register is fed only from the buffer head, never from imem_rdata.
        if (!stall) begin
            if (!fifo_empty) begin
                instr_d       = fifo_head.instr;
                instr_pc_d    = fifo_head.pc;
                instr_valid_d = 1'b1;
            end else begin
                instr_d       = DLX_NOP;
                instr_valid_d = 1'b0;
            end
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_aligned;
            resp_pc_d     = redirect_aligned;
            drop_d        = outstanding_d;
            state_d       = (outstanding_d != '0) ? FLUSH : RUN;
            instr_d       = DLX_NOP;
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            instr_q       <= DLX_NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n) imem_rvalid |-> (outstanding_q != '0)
    );

`ifdef DLX_FETCH_PERF_EN
    logic [31:0] perf_bubbles_q;
    logic [15:0] perf_redirects_q;
    logic [15:0] perf_dropped_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_bubbles_q   <= '0;
            perf_redirects_q <= '0;
            perf_dropped_q   <= '0;
        end else begin
            if (!instr_valid_q && !stall && (perf_bubbles_q != '1)) begin
                perf_bubbles_q <= perf_bubbles_q + 1'b1;
            end
            if (redirect_valid && (perf_redirects_q != '1)) begin
                perf_redirects_q <= perf_redirects_q + 1'b1;
            end
            if (drop_resp && (perf_dropped_q != '1)) begin
                perf_dropped_q <= perf_dropped_q + 1'b1;
            end
        end
    end

    assign perf_bubbles   = perf_bubbles_q;
    assign perf_redirects = perf_redirects_q;
    assign perf_dropped   = perf_dropped_q;
`endif

endmodule

// File: tb/tb_dlx_fetch.sv
// Bench for dlx_fetch: per-cycle stimulus rows with optional request checks,
// an in-bench memory returning addr+100 one cycle after issue, and a queue of
// expected {instr, pc} entries pushed as responses are returned and popped as
// fresh valid instructions appear at the decoder side.
module tb_dlx_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef DLX_FETCH_PERF_EN
    logic [31:0] perf_bubbles;
    logic [15:0] perf_redirects;
    logic [15:0] perf_dropped;
`endif

    dlx_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid)
`ifdef DLX_FETCH_PERF_EN
        ,
        .perf_bubbles   (perf_bubbles),
        .perf_redirects (perf_redirects),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          gnt;
        bit          ren;
        bit          creq;
        bit          ereq;
        logic [31:0] eaddr;
    } row_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic [31:0] mem_q[$];
    exp_t        exp_q[$];
    int          drop_cnt;
    int          bubble_cnt;
    int          cyc_no;
    int          first_valid;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_instr;
    logic [31:0] last_pc;
    logic        last_valid;

    row_t tab_a[27];
    row_t tab_b[10];

    function automatic row_t mk(bit st, bit rd, logic [31:0] rpc, bit gnt, bit ren,
                                bit creq, bit ereq, logic [31:0] eaddr);
        row_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.gnt = gnt; r.ren = ren;
        r.creq = creq; r.ereq = ereq; r.eaddr = eaddr;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h (row %0d)", nm, act, exp, cyc_no);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        mem_q.delete();
        exp_q.delete();
        drop_cnt    = 0;
        bubble_cnt  = 0;
        cyc_no      = 0;
        first_valid = -1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_instr", instr, 32'h0000_0000);
        check("rst_pc", instr_pc, 32'h0000_0000);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
`ifdef DLX_FETCH_PERF_EN
        check("rst_perf_bub", perf_bubbles, 32'd0);
        check("rst_perf_red", {16'd0, perf_redirects}, 32'd0);
        check("rst_perf_drop", {16'd0, perf_dropped}, 32'd0);
`endif
        last_instr = instr;
        last_pc    = instr_pc;
        last_valid = instr_valid;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Entered at a negedge; applies one row across the next posedge.
    task automatic cyc(input row_t r);
        logic [31:0] a;
        exp_t        e;
        if (r.ren && (mem_q.size() > 0)) begin
            a           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = a + 32'd100;
            if (!r.rd) begin
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    e.instr = a + 32'd100;
                    e.pc    = a;
                    exp_q.push_back(e);
                end
            end
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        stall          = r.st;
        redirect_valid = r.rd;
        redirect_pc    = r.rpc;
        imem_gnt       = r.gnt;
        if (r.rd) begin
            exp_q.delete();
            drop_cnt = mem_q.size();
        end
        #1;
        if (r.creq) begin
            check("imem_req", {31'd0, imem_req}, {31'd0, r.ereq});
            if (r.ereq) check("imem_addr", imem_addr, r.eaddr);
        end
        if (!instr_valid && !r.st) bubble_cnt++;
        if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
        @(posedge clk);
        #1;
        if (r.rd) begin
            check("redir_valid", {31'd0, instr_valid}, 32'd0);
            check("redir_nop", instr, 32'h0000_0000);
        end else if (r.st) begin
            check("hold_instr", instr, last_instr);
            check("hold_pc", instr_pc, last_pc);
            check("hold_valid", {31'd0, instr_valid}, {31'd0, last_valid});
        end else if (instr_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got pc %08h instr %08h want none (row %0d)",
                         instr_pc, instr, cyc_no);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_pc", instr_pc, e.pc);
            end
        end else begin
            check("bubble_nop", instr, 32'h0000_0000);
        end
        if (instr_valid && (first_valid < 0)) first_valid = cyc_no;
        last_instr = instr;
        last_pc    = instr_pc;
        last_valid = instr_valid;
        cyc_no++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            st rd rpc            gnt ren creq ereq eaddr
        tab_a[0]  = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0000);
        tab_a[1]  = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0004);
        tab_a[2]  = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[3]  = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0008);
        tab_a[4]  = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_000C);
        tab_a[5]  = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[6]  = mk(1, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0010);
        tab_a[7]  = mk(1, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[8]  = mk(1, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[9]  = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[10] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0014);
        tab_a[11] = mk(0, 0, 32'h0,        1,  0,  1,   1,   32'h0000_0018);
        tab_a[12] = mk(0, 1, 32'h0000_0043, 1, 0,  1,   0,   32'h0);
        tab_a[13] = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[14] = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[15] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0040);
        tab_a[16] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0044);
        tab_a[17] = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[18] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0048);
        tab_a[19] = mk(1, 1, 32'hFFFF_FFFF, 1, 1,  1,   0,   32'h0);
        tab_a[20] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'hFFFF_FFFC);
        tab_a[21] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0000);
        tab_a[22] = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_a[23] = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0004);
        tab_a[24] = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);
        tab_a[25] = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);
        tab_a[26] = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);

        tab_b[0]  = mk(0, 0, 32'h0,        1,  0,  1,   1,   32'h0000_0000);
        tab_b[1]  = mk(0, 1, 32'h0000_0100, 1, 0,  1,   0,   32'h0);
        tab_b[2]  = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_b[3]  = mk(0, 0, 32'h0,        1,  0,  1,   1,   32'h0000_0100);
        tab_b[4]  = mk(0, 1, 32'h0000_0200, 1, 0,  1,   0,   32'h0);
        tab_b[5]  = mk(0, 0, 32'h0,        1,  1,  1,   0,   32'h0);
        tab_b[6]  = mk(0, 0, 32'h0,        1,  1,  1,   1,   32'h0000_0200);
        tab_b[7]  = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);
        tab_b[8]  = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);
        tab_b[9]  = mk(0, 0, 32'h0,        0,  1,  0,   0,   32'h0);

        reset_n = 1'b0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 27; i++) cyc(tab_a[i]);
        check("first_valid_cycle", first_valid, 32'd2);
        check("sb_drained_a", exp_q.size(), 32'd0);

        do_reset();
        for (int i = 0; i < 10; i++) cyc(tab_b[i]);
        check("sb_drained_b", exp_q.size(), 32'd0);
`ifdef DLX_FETCH_PERF_EN
        check("perf_redirects", {16'd0, perf_redirects}, 32'd2);
        check("perf_dropped", {16'd0, perf_dropped}, 32'd2);
        check("perf_bubbles", perf_bubbles, bubble_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
